motion_cmd_arbiter: RTL
=======================

// Module: motion_cmd_arbiter
// PURPOSE
//  Sits between the Bluetooth command receiver / route follower and the motor driver.
//  Arbitrates the drive between manual (Bluetooth), autonomous (route follower) and
//  the obstacle/human sensor (highest priority).
//  Inserts a brake interval on direction reversal and a link-loss watchdog for manual drive.
//  Command codes: 011 fwd, 100 back, 101 left, 110 right, 111 stop, 001 route1, 010 route2.
// PARAMETERS
//  WDT_CYCLES    50_000_000  inclk cycles without bt_valid in MANUAL before forced stop
//  BRAKE_CYCLES   5_000_000  inclk cycles motor_cmd held at 111 on reversal/mode change
// PORTS
//  inclk      in   1  system clock, single clock domain
//  rst_n      in   1  asynchronous active-low reset
//  bt_cmd     in   3  decoded Bluetooth command, sampled only when bt_valid=1
//  bt_valid   in   1  one-cycle strobe, a new bt_cmd has arrived
//  auto_cmd   in   3  motion code from route follower (011..111)
//  auto_ready in   1  auto_cmd is valid
//  obstacle   in   1  sensor, active high, asynchronous (2-FF synchronised inside)
//  motor_cmd  out  3  registered drive code to motor driver
//  route_sel  out  2  00 none, 01 route1, 10 route2 (registered)
//  mode       out  2  current state: 00 IDLE, 01 MANUAL, 10 AUTO, 11 BRAKE
//  wdt_trip   out  1  sticky watchdog flag, cleared by next bt_valid
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - motor_cmd=111, route_sel=00, mode=IDLE, wdt_trip=0.
//   - Synchroniser, counters and pending target cleared.
//  All outputs are registered. bt_valid at edge N -> outputs updated at edge N+1.
//  FSM, on bt_valid:
//   - 000: ignored, no state change.
//   - 111: -> IDLE, route_sel=00. Valid from any state; aborts BRAKE immediately.
//   - 011..110: target MANUAL with that cmd. If current motor_cmd is the opposite
//     direction (011<->100), go to BRAKE first; otherwise go straight to MANUAL.
//   - 001/010: route_sel=01/10, target AUTO. Goes via BRAKE if motor_cmd!=111,
//     otherwise straight to AUTO.
//  IDLE:   motor_cmd=111.
//  MANUAL: motor_cmd = latched manual cmd.
//  AUTO:   motor_cmd = auto_cmd if auto_ready=1, else 111. Watchdog inactive.
//  BRAKE:  motor_cmd=111 for exactly BRAKE_CYCLES cycles, then enter the pending target.
//   - bt_valid with a non-111, non-000 cmd replaces the pending target.
//   - The brake counter is not restarted by a replacement.
//  Watchdog (MANUAL only):
//   - Counter clears on every bt_valid and on MANUAL entry.
//   - At WDT_CYCLES with no bt_valid: -> IDLE, motor_cmd=111, wdt_trip=1.
//   - bt_valid in the same cycle as expiry wins; no trip.
//  Obstacle (synchronised obs_s=1):
//   - motor_cmd is forced to 111 regardless of state.
//   - FSM, counters and bt_valid handling continue normally.
//   - On obs_s falling, motor_cmd resumes the state-derived value on the next edge.
//   - Latency: obstacle rise -> motor_cmd=111 by the 3rd inclk edge.
//  Counters are sized by $clog2 of their parameter and saturate; they never wrap.
// TESTING (WDT_CYCLES=20, BRAKE_CYCLES=4)
//  1. Reset, then bt_valid with 011 -> next cycle mode=01, motor_cmd=011.
//  2. In MANUAL 011, bt_valid with 100 -> mode=11 and motor_cmd=111 for 4 cycles,
//     then mode=01, motor_cmd=100.
//  3. MANUAL, no bt_valid for 20 cycles -> mode=00, motor_cmd=111, wdt_trip=1;
//     next bt_valid 101 -> wdt_trip=0, motor_cmd=101.
//  4. bt_valid 010 while stopped -> route_sel=10, mode=10; auto_ready=1 with
//     auto_cmd=101 -> motor_cmd=101; auto_ready=0 -> motor_cmd=111.
//  5. MANUAL 011, obstacle pulse of 10 cycles -> motor_cmd=111 within 3 edges;
//     back to 011 after release; mode stays 01 throughout.
//  6. In BRAKE, bt_valid 111 -> mode=00 next edge. rst_n low mid-BRAKE ->
//     all outputs at reset values immediately.

Source files
------------

// File: rtl/motion_cmd_arbiter_if.sv
// Handshake/drive bundle between the command sources and the motion arbiter.
// The master side feeds commands and sensor input; the slave side drives the motor.
interface motion_cmd_arbiter_if;
  logic [2:0] bt_cmd;
  logic       bt_valid;
  logic [2:0] auto_cmd;
  logic       auto_ready;
  logic       obstacle;
  logic [2:0] motor_cmd;
  logic [1:0] route_sel;
  logic [1:0] mode;
  logic       wdt_trip;

  modport master (
    output bt_cmd, bt_valid, auto_cmd, auto_ready, obstacle,
    input  motor_cmd, route_sel, mode, wdt_trip
  );

  modport slave (
    input  bt_cmd, bt_valid, auto_cmd, auto_ready, obstacle,
    output motor_cmd, route_sel, mode, wdt_trip
  );
endinterface

// File: rtl/motion_cmd_arbiter.sv
// Motion arbiter: manual/auto/obstacle drive selection with reversal brake
// and a link-loss watchdog on manual drive.
module motion_cmd_arbiter #(
  parameter int WDT_CYCLES   = 50_000_000,
  parameter int BRAKE_CYCLES = 5_000_000
) (
  input logic                 inclk,
  input logic                 rst_n,
  motion_cmd_arbiter_if.slave bus
);

  localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam int BW = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  localparam logic [BW-1:0] BRK_LAST = BW'(BRAKE_CYCLES - 1);

  localparam logic [2:0] C_FWD  = 3'b011;
  localparam logic [2:0] C_BACK = 3'b100;
  localparam logic [2:0] C_STOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_MAN   = 2'b01,
    S_AUTO  = 2'b10,
    S_BRAKE = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_tgt_auto;
  logic          w_tgt_auto_nxt;
  logic [2:0]    r_man_cmd;
  logic [2:0]    w_man_nxt;
  logic [1:0]    r_route;
  logic [1:0]    w_route_nxt;
  logic          r_trip;
  logic          w_trip_nxt;
  logic [2:0]    r_motor;
  logic [2:0]    w_motor_nxt;
  logic          r_sync1;
  logic          r_obs_s;
  logic [WW-1:0] r_wdt_cnt;
  logic [BW-1:0] r_brk_cnt;

  logic w_v;
  logic w_cmd_stop;
  logic w_cmd_man;
  logic w_cmd_rte;
  logic w_rev;
  logic w_brk_done;
  logic w_wdt_exp;

  assign w_v        = bus.bt_valid;
  assign w_cmd_stop = w_v && (bus.bt_cmd == C_STOP);
  assign w_cmd_man  = w_v && (bus.bt_cmd >= C_FWD)
                          && (bus.bt_cmd != C_STOP);
  assign w_cmd_rte  = w_v && ((bus.bt_cmd == 3'b001)
                          ||  (bus.bt_cmd == 3'b010));
  assign w_rev = ((bus.bt_cmd == C_FWD) && (r_motor == C_BACK))
              || ((bus.bt_cmd == C_BACK) && (r_motor == C_FWD));
  assign w_brk_done = (r_brk_cnt == BRK_LAST);
  assign w_wdt_exp  = (r_wdt_cnt == WDT_LAST) && !w_v;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tgt_auto <= 1'b0;
      r_man_cmd  <= C_STOP;
      r_route    <= 2'b00;
      r_trip     <= 1'b0;
      r_motor    <= C_STOP;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt_auto <= w_tgt_auto_nxt;
      r_man_cmd  <= w_man_nxt;
      r_route    <= w_route_nxt;
      r_trip     <= w_trip_nxt;
      r_motor    <= w_motor_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tgt_auto_nxt = r_tgt_auto;
    w_man_nxt      = r_man_cmd;
    w_route_nxt    = r_route;
    unique case (1'b1)
      w_cmd_stop: begin
        w_state_nxt = S_IDLE;
        w_route_nxt = 2'b00;
      end
      w_cmd_man: begin
        w_man_nxt      = bus.bt_cmd;
        w_tgt_auto_nxt = 1'b0;
        if (r_state == S_BRAKE)
          w_state_nxt = w_brk_done ? S_MAN : S_BRAKE;
        else
          w_state_nxt = w_rev ? S_BRAKE : S_MAN;
      end
      w_cmd_rte: begin
        w_route_nxt    = bus.bt_cmd[1:0];
        w_tgt_auto_nxt = 1'b1;
        if (r_state == S_BRAKE)
          w_state_nxt = w_brk_done ? S_AUTO : S_BRAKE;
        else
          w_state_nxt = (r_motor != C_STOP) ? S_BRAKE : S_AUTO;
      end
      default: begin
        if ((r_state == S_BRAKE) && w_brk_done)
          w_state_nxt = r_tgt_auto ? S_AUTO : S_MAN;
        else if ((r_state == S_MAN) && w_wdt_exp)
          w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_motor_nxt = C_STOP;
    w_trip_nxt  = r_trip;
    if (w_v)
      w_trip_nxt = 1'b0;
    else if ((r_state == S_MAN) && w_wdt_exp)
      w_trip_nxt = 1'b1;
    if (!r_obs_s) begin
      unique case (w_state_nxt)
        S_MAN:   w_motor_nxt = w_man_nxt;
        S_AUTO:  w_motor_nxt = bus.auto_ready ? bus.auto_cmd : C_STOP;
        default: w_motor_nxt = C_STOP;
      endcase
    end
  end

  // Obstacle is asynchronous; two flops before it may gate the motor.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_obs_s <= 1'b0;
    end else begin
      r_sync1 <= bus.obstacle;
      r_obs_s <= r_sync1;
    end
  end

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt <= '0;
      r_brk_cnt <= '0;
    end else begin
      if ((r_state != S_MAN) || w_v)
        r_wdt_cnt <= '0;
      else if (r_wdt_cnt != WDT_LAST)
        r_wdt_cnt <= r_wdt_cnt + 1'b1;
      if (r_state != S_BRAKE)
        r_brk_cnt <= '0;
      else if (!w_brk_done)
        r_brk_cnt <= r_brk_cnt + 1'b1;
    end
  end

  assign bus.motor_cmd = r_motor;
  assign bus.route_sel = r_route;
  assign bus.mode      = r_state;
  assign bus.wdt_trip  = r_trip;

endmodule
